lsu_data_memory: RTL and testbench

LSU_DATA_MEMORY -- requirements
Module: lsu_data_memory

---
 rtl/lsu_data_memory.sv | 143 ++++++++++++++
 tb/tb_lsu_data_memory.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_data_memory.sv
// Word-organised data memory behind a load/store request/response handshake.
// Sub-word stores use byte enables; loads are captured at accept and extended on return.
module lsu_data_memory #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [2:0]    wait_cnt_q, wait_cnt_d;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          accept;
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_rep;
  logic          size_ok, misaligned, out_of_range, access_err;
  logic [31:0]   mem_word, lane_data, rdata_ext;

  assign accept       = req_valid && req_ready;
  assign word_idx     = req_addr[AW+1:2];
  assign out_of_range = |req_addr[31:AW+2];

  // Size decode. With alignment checking off, the lane is forced to the natural boundary.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    size_ok    = 1'b1;
    misaligned = 1'b0;
    lane       = req_addr[1:0];
    byte_en    = 4'b0000;
    wdata_rep  = req_wdata;
    case (req_size)
      3'b000, 3'b100: begin
        byte_en   = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        misaligned = req_addr[0];
        lane       = {req_addr[1], 1'b0};
        byte_en    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{req_wdata[15:0]}};
      end
      3'b010: begin
        misaligned = |req_addr[1:0];
        lane       = 2'b00;
        byte_en    = 4'b1111;
      end
      default: size_ok = 1'b0;
    endcase
  end

  assign access_err = out_of_range || !size_ok || (CHECK_ALIGN && misaligned);

  assign mem_word  = mem[word_idx];
  assign lane_data = mem_word >> {lane, 3'b000};

  always_comb begin
    case (req_size)
      3'b000:  rdata_ext = {{24{lane_data[7]}}, lane_data[7:0]};
      3'b100:  rdata_ext = {24'h0, lane_data[7:0]};
      3'b001:  rdata_ext = {{16{lane_data[15]}}, lane_data[15:0]};
      3'b101:  rdata_ext = {16'h0, lane_data[15:0]};
      default: rdata_ext = mem_word;
    endcase
  end

  // NOTE: the storage array has no reset; contents survive rst and stay mappable to RAM.
  always_ff @(posedge clk) begin
    if (accept && req_we && !access_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d    = WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_q == 3'd0) state_d = RESP;
        else                    wait_cnt_d = wait_cnt_q - 3'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // req_ready is registered so it stays low through reset and rises one edge after release.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= 3'd0;
      req_ready  <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      req_ready  <= (state_d == IDLE);
      if (accept) begin
        err_q   <= access_err;
        rdata_q <= (access_err || req_we) ? 32'h0 : rdata_ext;
      end
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign resp_err   = resp_valid && err_q;

endmodule

// File: tb/tb_lsu_data_memory.sv
// Self-checking bench for lsu_data_memory: two instances (WS=0/align-check, WS=3/force-align)
// compared against a byte-addressed little-endian reference memory.
module tb_lsu_data_memory;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  logic        clk;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [2:0]  req_size   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference: first 64 bytes of each instance, byte addressed.
  logic [7:0] mref [2][64];
  logic [2:0] size_pool [8];

  lsu_data_memory #(.DEPTH(1024), .WAIT_STATES(0), .CHECK_ALIGN(1'b1)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_size(req_size[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  lsu_data_memory #(.DEPTH(64), .WAIT_STATES(3), .CHECK_ALIGN(1'b0)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_size(req_size[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  function automatic int ws_of(input int u);
    return (u == 0) ? 0 : 3;
  endfunction

  function automatic int depth_of(input int u);
    return (u == 0) ? 1024 : 64;
  endfunction

  function automatic bit ca_of(input int u);
    return (u == 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference access: returns the expected response and applies a legal store.
  task automatic ref_access(input int u, input bit we, input logic [2:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rd, output bit err);
    int          n;
    logic [31:0] a;
    logic [31:0] v;
    rd  = 32'h0;
    err = 1'b0;
    case (size)
      SZ_B, SZ_BU: n = 1;
      SZ_H, SZ_HU: n = 2;
      SZ_W:        n = 4;
      default:     n = 0;
    endcase
    if (n == 0) begin
      err = 1'b1;
      return;
    end
    if (addr >= 32'(depth_of(u) * 4)) err = 1'b1;
    if (ca_of(u) && (addr % n) != 0) err = 1'b1;
    if (err) return;
    a = addr - (addr % n);
    if (we) begin
      for (int i = 0; i < n; i++) mref[u][a + i] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(mref[u][a + i]) << (8 * i));
      case (size)
        SZ_B:    rd = {{24{v[7]}}, v[7:0]};
        SZ_H:    rd = {{16{v[15]}}, v[15:0]};
        default: rd = v;
      endcase
    end
  endtask

  // Drive one request and collect its response, with bounded waits throughout.
  task automatic txn(input int u, input bit we, input logic [2:0] size, input logic [31:0] addr,
                     input logic [31:0] wdata, input bit hold,
                     output logic [31:0] rd, output logic err, output int lat, output int low);
    int k;
    bit got;
    rd = 32'h0; err = 1'b0; lat = 0; low = 0; got = 1'b0;
    @(negedge clk);
    k = 0;
    while (req_ready[u] !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("u%0d ready_before_req", u), {31'b0, req_ready[u]}, 32'd1);
    req_valid[u] = 1'b1;
    req_we[u]    = we;
    req_size[u]  = size;
    req_addr[u]  = addr;
    req_wdata[u] = wdata;
    @(posedge clk);
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready[u] !== 1'b1) low++;
      if (resp_valid[u] === 1'b1) begin
        got = 1'b1;
        lat = c;
        rd  = resp_rdata[u];
        err = resp_err[u];
      end else begin
        check($sformatf("u%0d idle_rdata", u), resp_rdata[u], 32'h0);
        check($sformatf("u%0d idle_err", u), {31'b0, resp_err[u]}, 32'h0);
      end
      if (!hold || got) req_valid[u] = 1'b0;
    end
    req_valid[u] = 1'b0;
    check($sformatf("u%0d resp_seen", u), {31'b0, got}, 32'd1);
    @(negedge clk);
    check($sformatf("u%0d resp_one_cycle", u), {31'b0, resp_valid[u]}, 32'd0);
    check($sformatf("u%0d ready_back", u), {31'b0, req_ready[u]}, 32'd1);
  endtask

  task automatic op(input int u, input bit we, input logic [2:0] size, input logic [31:0] addr,
                    input logic [31:0] wdata, input bit hold,
                    output logic [31:0] rd, output logic err);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          lat, low;
    ref_access(u, we, size, addr, wdata, exp_rd, exp_err);
    txn(u, we, size, addr, wdata, hold, rd, err, lat, low);
    check($sformatf("u%0d we%0d sz%0d @%h rdata", u, we, size, addr), rd, exp_rd);
    check($sformatf("u%0d we%0d sz%0d @%h err", u, we, size, addr), {31'b0, err}, {31'b0, exp_err});
    check($sformatf("u%0d latency", u), 32'(lat), 32'(ws_of(u) + 1));
    check($sformatf("u%0d ready_low_cycles", u), 32'(low), 32'(ws_of(u) + 1));
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          extra;
    int          uu;
    logic [2:0]  sz;
    logic [31:0] a;

    size_pool = '{SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU, SZ_W, 3'b011, 3'b111};
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_we[u] = 1'b0; req_size[u] = SZ_W;
      req_addr[u] = 32'h0; req_wdata[u] = 32'h0;
    end

    // Power-up reset: outputs forced low asynchronously, ready one edge after release.
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("u%0d rst_ready", u), {31'b0, req_ready[u]}, 32'd0);
      check($sformatf("u%0d rst_valid", u), {31'b0, resp_valid[u]}, 32'd0);
      check($sformatf("u%0d rst_rdata", u), resp_rdata[u], 32'h0);
      check($sformatf("u%0d rst_err", u), {31'b0, resp_err[u]}, 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("ready_low_after_release", {31'b0, req_ready[0]}, 32'd0);
    @(negedge clk);
    check("u0 ready_first_edge", {31'b0, req_ready[0]}, 32'd1);
    check("u1 ready_first_edge", {31'b0, req_ready[1]}, 32'd1);

    // Word store/load, sub-word store and sign/zero-extended loads.
    op(0, 1'b1, SZ_W, 32'h10, 32'hDEAD_BEEF, 1'b0, rd, er);
    check("sw_resp_rdata", rd, 32'h0);
    op(0, 1'b0, SZ_W, 32'h10, 32'h0, 1'b0, rd, er);
    check("lw_deadbeef", rd, 32'hDEAD_BEEF);
    op(0, 1'b1, SZ_B, 32'h12, 32'h0000_0080, 1'b0, rd, er);
    op(0, 1'b0, SZ_B, 32'h12, 32'h0, 1'b0, rd, er);
    check("lb_sign", rd, 32'hFFFF_FF80);
    op(0, 1'b0, SZ_BU, 32'h12, 32'h0, 1'b0, rd, er);
    check("lbu_zero", rd, 32'h0000_0080);
    op(0, 1'b0, SZ_W, 32'h10, 32'h0, 1'b0, rd, er);
    check("lw_after_sb", rd, 32'hDE80_BEEF);

    // Misaligned halfword store is rejected and leaves memory untouched.
    op(0, 1'b1, SZ_H, 32'h13, 32'h0000_1234, 1'b0, rd, er);
    check("sh_misaligned_err", {31'b0, er}, 32'd1);
    op(0, 1'b0, SZ_W, 32'h10, 32'h0, 1'b0, rd, er);
    check("lw_unchanged", rd, 32'hDE80_BEEF);

    // Fill the modelled region so every later load has a known expectation.
    for (int u = 0; u < 2; u++)
      for (int w = 0; w < 16; w++) op(u, 1'b1, SZ_W, 32'(w * 4), $urandom, 1'b0, rd, er);

    // Out-of-range accesses: error, zero data, no wrap onto word 0.
    op(0, 1'b0, SZ_W, 32'h1000, 32'h0, 1'b0, rd, er);
    check("oor_load_err", {31'b0, er}, 32'd1);
    check("oor_load_rdata", rd, 32'h0);
    op(0, 1'b1, SZ_W, 32'h1000, 32'h5555_AAAA, 1'b0, rd, er);
    check("oor_store_err", {31'b0, er}, 32'd1);
    op(0, 1'b0, SZ_W, 32'h0, 32'h0, 1'b0, rd, er);
    op(0, 1'b0, 3'b011, 32'h0, 32'h0, 1'b0, rd, er);
    check("illegal_size_err", {31'b0, er}, 32'd1);

    // Force-aligned instance: low address bits masked, no error.
    op(1, 1'b1, SZ_W, 32'h20, 32'h8765_4321, 1'b0, rd, er);
    op(1, 1'b0, SZ_H, 32'h23, 32'h0, 1'b0, rd, er);
    check("fa_lh_masked", rd, 32'hFFFF_8765);
    check("fa_lh_noerr", {31'b0, er}, 32'd0);
    op(1, 1'b0, SZ_W, 32'h22, 32'h0, 1'b0, rd, er);
    check("fa_lw_masked", rd, 32'h8765_4321);
    op(1, 1'b1, SZ_H, 32'h21, 32'h0000_AAAA, 1'b0, rd, er);
    op(1, 1'b0, SZ_W, 32'h20, 32'h0, 1'b0, rd, er);
    check("fa_sh_masked", rd, 32'h8765_AAAA);

    // Randomized traffic on both instances.
    for (int i = 0; i < 160; i++) begin
      uu = int'($urandom_range(0, 1));
      sz = size_pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0)
        a = (uu == 0) ? 32'h1000 + $urandom_range(0, 255) : 32'h100 + $urandom_range(0, 255);
      else if ($urandom_range(0, 15) == 0)
        a = $urandom | 32'h4000_0000;
      else
        a = 32'($urandom_range(0, 63));
      op(uu, 1'($urandom_range(0, 1)), sz, a, $urandom, 1'b0, rd, er);
    end

    // WAIT_STATES=3 with req_valid held high: one response only.
    op(1, 1'b0, SZ_W, 32'h8, 32'h0, 1'b1, rd, er);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid[1] === 1'b1) extra++;
    end
    check("held_valid_single_resp", 32'(extra), 32'd0);

    // Reset during WAIT of a store: aborted, outputs low, store stays committed.
    @(negedge clk);
    check("pre_rst_ready", {31'b0, req_ready[1]}, 32'd1);
    ref_access(1, 1'b1, SZ_W, 32'h30, 32'hCAFE_F00D, rd, er);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = SZ_W;
    req_addr[1]  = 32'h30; req_wdata[1] = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("in_wait_no_resp", {31'b0, resp_valid[1]}, 32'd0);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, resp_valid[1]}, 32'd0);
    check("mid_rst_rdata", resp_rdata[1], 32'h0);
    check("mid_rst_err", {31'b0, resp_err[1]}, 32'd0);
    check("mid_rst_ready", {31'b0, req_ready[1]}, 32'd0);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid[0] === 1'b1 || resp_valid[1] === 1'b1) extra++;
    end
    rst = 1'b1;
    #1;
    check("post_rst_ready_low", {31'b0, req_ready[1]}, 32'd0);
    @(negedge clk);
    check("post_rst_ready_up", {31'b0, req_ready[1]}, 32'd1);
    repeat (6) begin
      @(negedge clk);
      if (resp_valid[0] === 1'b1 || resp_valid[1] === 1'b1) extra++;
    end
    check("aborted_no_resp", 32'(extra), 32'd0);
    op(1, 1'b0, SZ_W, 32'h30, 32'h0, 1'b0, rd, er);
    check("store_survives_rst", rd, 32'hCAFE_F00D);
    op(0, 1'b0, SZ_HU, 32'h10, 32'h0, 1'b0, rd, er);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
